// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: posted-store FIFO buffer in front of DATAMEM, 1-cycle load response.
// Build option MEMSTAGE_FWD_EN: store-buffer forwarding to loads (otherwise loads wait for an empty buffer).
module mem_stage_lsu #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_W     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [RD_W-1:0]           req_rd,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [RD_W-1:0]           resp_rd,
  output logic                      MemRead,
  output logic                      MemWrite,
  output logic [ADDR_W-1:0]         Addr,
  output logic [DATA_W-1:0]         Wdata,
  input  logic [DATA_W-1:0]         Rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SB_DEPTH-1:0][ADDR_W-1:0] sb_addr_q, sb_addr_d;
  logic [SB_DEPTH-1:0][DATA_W-1:0] sb_data_q, sb_data_d;
  logic [PTR_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]               resp_data_q, resp_data_d;
  logic [RD_W-1:0]                 resp_rd_q, resp_rd_d;

  logic              full, st_fire, ld_fire, mem_ld, drain, hit;
  logic [DATA_W-1:0] fwd_data;

  assign full = (cnt_q == CNT_W'(SB_DEPTH));

`ifdef MEMSTAGE_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest->youngest with last-match-wins, so the youngest matching store supplies the data.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) && (sb_addr_q[idx] == req_addr)) begin
        hit      = 1'b1;
        fwd_data = sb_data_q[idx];
      end
    end
  end

  assign req_ready = !full;
`else
  assign hit       = 1'b0;
  assign fwd_data  = '0;
  // Without forwarding a load may only go once every older store has reached memory.
  assign req_ready = req_is_store ? !full : (cnt_q == '0);
`endif

  assign st_fire = !reset && req_valid && req_ready &&  req_is_store;
  assign ld_fire = !reset && req_valid && req_ready && !req_is_store;
  assign mem_ld  = ld_fire && !hit;
  assign drain   = !reset && !mem_ld && (cnt_q != '0);

  always_comb begin
    sb_addr_d    = sb_addr_q;
    sb_data_d    = sb_data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    resp_valid_d = ld_fire;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    if (st_fire) begin
      sb_addr_d[tail_q] = req_addr;
      sb_data_d[tail_q] = req_wdata;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (drain) head_d = head_q + PTR_W'(1);
    case ({st_fire, drain})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (ld_fire) begin
      resp_data_d = hit ? fwd_data : Rdata;
      resp_rd_d   = req_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  // Entry storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    sb_addr_q <= sb_addr_d;
    sb_data_q <= sb_data_d;
  end

  assign MemRead    = mem_ld;
  assign MemWrite   = drain;
  assign Addr       = mem_ld ? req_addr : (drain ? sb_addr_q[head_q] : '0);
  assign Wdata      = drain ? sb_data_q[head_q] : '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign sb_count   = cnt_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu: program-order memory model plus pending-store queue as reference.
module tb_mem_stage_lsu;
  localparam int D = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       req_valid, req_ready, req_is_store;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_rd;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic [2:0] resp_rd;
  logic       MemRead, MemWrite;
  logic [7:0] Addr, Wdata, Rdata;
  logic [2:0] sb_count;

  always #5 clk = ~clk;

  mem_stage_lsu #(.SB_DEPTH(D), .ADDR_W(8), .DATA_W(8), .RD_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata),
    .sb_count(sb_count)
  );

  // DATAMEM stand-in
  logic [7:0] dut_mem    [256];
  logic [7:0] commit_mem [256];
  logic       load_mem;
  always @(posedge clk)
    if (load_mem) dut_mem <= commit_mem;
    else if (MemWrite) dut_mem[Addr] <= Wdata;
  assign Rdata = dut_mem[Addr];

  typedef struct {logic [7:0] a; logic [7:0] d;} st_t;
  st_t        sbq[$];
  int         n_chk = 0, n_pass = 0;
  logic       exp_rv, fired;
  logic [7:0] exp_rdata;
  logic [2:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // One clock: check outputs at negedge against the model, advance the model, drive next at posedge+1.
  task automatic step();
    logic       stf, ldf, hit, exp_mr, exp_mw, exp_ready;
    logic [7:0] ld_val;
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("resp_data", 32'(resp_data), 32'(exp_rdata));
      chk("resp_rd", 32'(resp_rd), 32'(exp_rd));
    end
    chk("sb_count", 32'(sb_count), 32'(sbq.size()));
`ifdef MEMSTAGE_FWD_EN
    exp_ready = sbq.size() < D;
`else
    exp_ready = req_is_store ? (sbq.size() < D) : (sbq.size() == 0);
`endif
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    stf    = req_valid && exp_ready && req_is_store;
    ldf    = req_valid && exp_ready && !req_is_store;
    hit    = 1'b0;
    ld_val = commit_mem[req_addr];
    foreach (sbq[i]) if (sbq[i].a == req_addr) begin hit = 1'b1; ld_val = sbq[i].d; end
    exp_mr = ldf && !hit;
    exp_mw = !exp_mr && (sbq.size() > 0);
    chk("MemRead", 32'(MemRead), 32'(exp_mr));
    chk("MemWrite", 32'(MemWrite), 32'(exp_mw));
    if (exp_mr) chk("ld_addr", 32'(Addr), 32'(req_addr));
    else if (exp_mw) begin
      chk("wr_addr", 32'(Addr), 32'(sbq[0].a));
      chk("wr_data", 32'(Wdata), 32'(sbq[0].d));
    end else begin
      chk("idle_addr", 32'(Addr), 32'(0));
      chk("idle_wdata", 32'(Wdata), 32'(0));
    end
    if (exp_mw) begin
      commit_mem[sbq[0].a] = sbq[0].d;
      void'(sbq.pop_front());
    end
    if (stf) sbq.push_back('{req_addr, req_wdata});
    exp_rv = ldf;
    if (ldf) begin exp_rdata = ld_val; exp_rd = req_rd; end
    fired = stf || ldf;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic st, input logic [7:0] a, input logic [7:0] d, input logic [2:0] rd);
    int n = 0;
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = d; req_rd = rd;
    do begin step(); n++; end while (!fired && n < 50);
    chk("accepted", 32'(fired), 32'(1));
    req_valid = 1'b0;
  endtask

  // Reset discards everything buffered; committed memory is untouched.
  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_MemRead", 32'(MemRead), 32'(0));
    chk("rst_MemWrite", 32'(MemWrite), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    exp_rv = 1'b0;
  endtask

  initial begin
    req_valid = 0; req_is_store = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    exp_rv = 0; exp_rdata = 0; exp_rd = 0; fired = 0;
    foreach (commit_mem[i]) commit_mem[i] = 8'($urandom);
    commit_mem[8'h10] = 8'h00;
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0;
    do_reset();
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_data", 32'(resp_data), 32'(0));
    chk("rst_resp_rd", 32'(resp_rd), 32'(0));
    chk("rst_sb_count", 32'(sb_count), 32'(0));

    issue(0, 8'h10, 8'h00, 3'd1); idle(1);
    issue(1, 8'h10, 8'hAB, 3'd0); idle(3);
    issue(0, 8'h10, 8'h00, 3'd2); idle(1);
    for (int i = 0; i < 5; i++) begin
      issue(1, 8'h40 + 8'(i), 8'($urandom), 3'd0);
      issue(0, 8'h50 + 8'(i), 8'h00, 3'd3);
    end
    idle(4);
    issue(1, 8'h20, 8'h11, 3'd0);
    issue(1, 8'h20, 8'h22, 3'd0);
    issue(0, 8'h20, 8'h00, 3'd4); idle(2);
    for (int i = 0; i < 8; i++) issue(1, 8'h60 + 8'(i), 8'($urandom), 3'd0);
    idle(4);
    issue(1, 8'h30, 8'hC0, 3'd0);
    issue(1, 8'h31, 8'hC1, 3'd0);
    issue(1, 8'h32, 8'hC2, 3'd0);
    do_reset();
    issue(0, 8'h32, 8'h00, 3'd5); idle(1);

    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 25) idle(1);
      else issue(1'($urandom_range(0, 1)), 8'h10 + 8'($urandom_range(0, 7)),
                 8'($urandom), 3'($urandom));
    end
    idle(6);
    for (int a = 0; a < 256; a++) chk("final_mem", 32'(dut_mem[a]), 32'(commit_mem[a]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
